// File: rtl/ecc_75_enc_fault_detc_if.sv
// Purpose : write-side beat bus for the 75-bit ECC encoder (input beat + encoded output beat).
// Latency : none; signal bundle only.
// Backpressure: valid/ready on both sides; in_ready/out_valid are driven by the encoder.
// Ports   : in_valid/in_ready/data_in (write port), out_valid/out_ready/data_out/parity_out/ecc_fault (RAM side).
interface ecc_75_enc_fault_detc_if #(
  parameter int DATA_WIDTH   = 75,
  parameter int PARITY_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [PARITY_WIDTH-1:0] parity_out;
  logic                    ecc_fault;

  // master: FIFO write side + RAM sink; slave: the encoder itself
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, parity_out, ecc_fault
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, parity_out, ecc_fault
  );
endinterface

// File: rtl/ecc_75_enc_fault_detc.sv
// Purpose : SEC-DED write-side encoder with duplicated encoder copies compared per beat for fault detection.
// Latency : beat accepted at edge N is presented (out_valid=1) after edge N+1; full throughput with out_ready=1.
// Backpressure: s1 holds while out_ready=0, s0 absorbs one more beat, then in_ready drops.
// Ports   : clk, rst (sync, active-high); ecc_fault_detc_en/bypass/inject_en sampled with the beat;
//           fault_clr clears sticky+counter; bus = beat interface; ecc_fault_sticky, fault_cnt (saturating).
module ecc_75_enc_fault_detc #(
  parameter int DATA_WIDTH      = 75,
  parameter int PARITY_WIDTH    = 8,
  parameter int FAULT_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ecc_fault_detc_en,
  input  logic                       bypass,
  input  logic                       inject_en,
  input  logic                       fault_clr,
  ecc_75_enc_fault_detc_if.slave     bus,
  output logic                       ecc_fault_sticky,
  output logic [FAULT_CNT_WIDTH-1:0] fault_cnt
);

  // Hamming bits; the top parity bit is the overall parity
  localparam int HW   = PARITY_WIDTH - 1;
  localparam int NPOS = DATA_WIDTH + HW;

  // Selects the data bits that feed Hamming bit b. Data bits occupy codeword
  // positions 1..NPOS that are not powers of two, in ascending order.
  function automatic logic [DATA_WIDTH-1:0] hmask(input int b);
    logic [DATA_WIDTH-1:0] m;
    int                    k;
    m = '0;
    k = 0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> b) & 1) != 0) begin
          m = m | ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << k);
        end
        k++;
      end
    end
    return m;
  endfunction

  // Stage 0 registers
  logic                  s0_valid;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_bypass;
  logic                  s0_inject;
  logic                  s0_en;

  // Stage 1 registers
  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_parity;
  logic                    s1_fault;

  // Two encoder copies evaluated from the s0 register
  logic [HW-1:0]           ham0;
  logic [HW-1:0]           ham1;
  logic [PARITY_WIDTH-1:0] par0;
  logic [PARITY_WIDTH-1:0] par1;
  logic                    mism;

  for (genvar b = 0; b < HW; b++) begin : g_ham
    localparam logic [DATA_WIDTH-1:0] MASK = hmask(b);
    assign ham0[b] = ^(s0_data & MASK);
    assign ham1[b] = ^(s0_data & MASK);
  end

  always_comb begin
    par0 = '0;
    par1 = '0;
    if (!s0_bypass) begin
      par0 = {(^s0_data) ^ (^ham0), ham0};
      par1 = {(^s0_data) ^ (^ham1), ham1};
    end
    // fault injection corrupts only the checking copy, so parity_out stays valid
    par1 = par1 ^ {{(PARITY_WIDTH-1){1'b0}}, s0_inject};
    mism = (par0 != par1) && s0_en;
  end

  logic s1_load;
  logic s0_take;

  always_comb begin
    s1_load = s0_valid && (!s1_valid || bus.out_ready);
    // in_ready from s0 occupancy and the s1 move, never from in_valid
    bus.in_ready = !s0_valid || s1_load;
    s0_take = bus.in_valid && bus.in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid         <= 1'b0;
      s0_data          <= '0;
      s0_bypass        <= 1'b0;
      s0_inject        <= 1'b0;
      s0_en            <= 1'b0;
      s1_valid         <= 1'b0;
      s1_data          <= '0;
      s1_parity        <= '0;
      s1_fault         <= 1'b0;
      fault_cnt        <= '0;
      ecc_fault_sticky <= 1'b0;
    end else begin
      if (s0_take) begin
        s0_valid  <= 1'b1;
        s0_data   <= bus.data_in;
        s0_bypass <= bypass;
        s0_inject <= inject_en;
        s0_en     <= ecc_fault_detc_en;
      end else if (s1_load) begin
        s0_valid <= 1'b0;
      end

      if (s1_load) begin
        s1_valid  <= 1'b1;
        s1_data   <= s0_data;
        s1_parity <= par0;
        s1_fault  <= mism;
      end else if (bus.out_ready) begin
        s1_valid <= 1'b0;
      end

      // clear wins over a same-edge faulty load
      if (fault_clr) begin
        fault_cnt        <= '0;
        ecc_fault_sticky <= 1'b0;
      end else if (s1_load && mism) begin
        ecc_fault_sticky <= 1'b1;
        if (fault_cnt != '1) begin
          fault_cnt <= fault_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid  = s1_valid;
  assign bus.data_out   = s1_data;
  assign bus.parity_out = s1_parity;
  assign bus.ecc_fault  = s1_fault;

endmodule

// File: doc/ecc_75_enc_fault_detc.md
# ecc_75_enc_fault_detc

Write-side SEC-DED encoder for the 75-bit FIFO datapath. It is the counterpart of the `ecc_75_fault_detc` read-side checker.
- Two independent encoder copies compute parity for each beat, and the results are compared to detect faults inside the encoder logic.
- The beat travels through a two-stage valid/ready pipeline.
- Fault status is reported per beat, as a sticky flag, and as a saturating counter.
- The block sits between the FIFO write port and the RAM write data/parity.

## Interface
- `DATA_WIDTH`, 75, data word width
- `PARITY_WIDTH`, 8, parity width (7 Hamming bits + 1 overall)
- `FAULT_CNT_WIDTH`, 8, fault counter width
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ecc_fault_detc_en`  in  1  enable for the encoder-copy comparison
- `bypass`  in  1  when 1, both copies output parity 0
- `inject_en`  in  1  test only: inverts parity bit 0 of copy 1
- `fault_clr`  in  1  clears the sticky flag and the counter
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`
- `data_in`  in  DATA_WIDTH  write data
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts the beat
- `data_out`  out  DATA_WIDTH  registered data
- `parity_out`  out  PARITY_WIDTH  copy-0 parity
- `ecc_fault`  out  1  per-beat flag: the two copies mismatched; qualified by `out_valid`
- `ecc_fault_sticky`  out  1  set on any faulty beat, held until `fault_clr`
- `fault_cnt`  out  FAULT_CNT_WIDTH  count of faulty beats, saturating

## Operation
- **Code definition**
  - The 75 data bits fill codeword positions 1..82 that are not powers of two, in ascending order: data[0] goes to position 3, data[1] to position 5, and so on.
  - p[i] (i = 0..6) is the XOR of the data bits whose position has bit i set.
  - p[7] is the XOR of all data bits and p[6:0].
  - This code is identical to what the read-side decoder checks.
- **Stage 0 (s0)**
  - Registers `data_in`, `bypass` and `inject_en` on input handshake.
  - Both encoder copies evaluate combinationally from the s0 register.
- **Stage 1 (s1)**
  - Registers the s0 data, copy-0 parity and `mism`.
  - `mism = (par0 != par1) & ecc_fault_detc_en`.
  - `ecc_fault` is the registered value of `mism`.
  - Parity is always taken from copy 0; data is never altered.
- **Bypass**
  - Both copies produce 8'h00, so `mism` = 0 unless `inject_en` is set.
  - `inject_en` still flips par1[0] in bypass.
- **Flow control**
  - s1 loads when `s0_valid & (~s1_valid | out_ready)`.
  - `in_ready = ~s0_valid | s1 loads`.
  - With `out_ready` = 1 the block sustains full throughput.
- **Counter and sticky flag**
  - On each s1 load with `mism` = 1: `fault_cnt` increments, saturating at all-ones, and `ecc_fault_sticky` is set.
  - `fault_clr` has priority over a same-cycle increment: the result is cnt = 0 and sticky = 0.
- **Register stability**
  - `ecc_fault_detc_en`, `bypass` and `inject_en` are sampled with the beat at s0 capture.
  - Changing them afterwards does not affect beats already in flight.

## Timing
- **Reset values** (synchronous `rst`): all of the following are 0 on the first edge with `rst` = 1.
  - `out_valid`, `data_out`, `parity_out`, `ecc_fault`, `ecc_fault_sticky`, `fault_cnt`, and internal `s0_valid`.
  - `in_ready` = 1 combinationally once s0 is empty.
- **Latency**: a beat accepted at edge N is presented with `out_valid` = 1 after edge N+1.
- **Backpressure**
  - With `out_ready` = 0, s1 holds its contents.
  - s0 fills one more beat, then `in_ready` drops.
  - `data_out`, `parity_out` and `ecc_fault` remain stable while `out_valid & ~out_ready`.
- **Simultaneous release and accept**
  - With a full pipeline, `out_ready` = 1 and `in_valid` = 1 in the same cycle, s1 takes s0 and s0 takes the new beat. No bubble.
- **Reset mid-operation**
  - In-flight beats are discarded; no partial beat is output.
  - The counter and sticky flag clear.
- `fault_cnt` updates on the same edge that loads the faulty beat into s1, so it is visible together with `ecc_fault`.

## Test plan
- **Encode values**: `data_in` = 0, then 1, then 2, with `out_ready` = 1.
  - `parity_out` = 8'h00, 8'h83, 8'h85 respectively.
  - Each beat appears 2 cycles after input; `ecc_fault` = 0.
- **Injected fault**: `inject_en` = 1, `ecc_fault_detc_en` = 1, `data_in` = 1.
  - `ecc_fault` = 1 with the beat.
  - `parity_out` = 8'h83 (copy 0).
  - `fault_cnt` = 1 and `ecc_fault_sticky` = 1.
- **Detection disabled**: repeat with `ecc_fault_detc_en` = 0.
  - `ecc_fault` = 0 and `fault_cnt` unchanged.
  - Then `fault_clr` = 1 for 1 cycle clears cnt and sticky to 0.
- **Backpressure**: stream 5 beats with `out_ready` held 0 for 4 cycles.
  - `in_ready` falls after 2 beats accepted.
  - Output stays stable; all 5 beats are delivered in order, with no loss or duplication.
- **Saturation and clear priority**: `FAULT_CNT_WIDTH` = 2, 5 injected beats.
  - `fault_cnt` saturates at 3.
  - `fault_clr` asserted in the same cycle as a faulty load gives cnt = 0 and sticky = 0.
- **Reset mid-stream**: `rst` = 1 for one cycle while both stages are full.
  - Next cycle `out_valid` = 0, `in_ready` = 1, `fault_cnt` = 0.
  - No stale beat is output afterwards.
